// File: rtl/axi_spm_responder.sv
// AXI4 slave serving compact-ID bursts from an on-chip scratchpad, with independent single-outstanding read/write FSMs.
// Define SPM_RANGE_CHECK_EN to flag start addresses beyond the SPM and answer them with SLVERR.
module axi_spm_responder #(
  parameter int SPM_SIZE_IN_BYTE     = 65536,
  parameter int C_S00_AXI_ID_WIDTH   = 4,
  parameter int C_S00_AXI_ADDR_WIDTH = 40,
  parameter int C_S00_AXI_DATA_WIDTH = 128
) (
  input  logic                                s00_axi_aclk,
  input  logic                                s00_axi_areset,
  input  logic [C_S00_AXI_ID_WIDTH-1:0]       s00_axi_awid,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [7:0]                          s00_axi_awlen,
  input  logic [1:0]                          s00_axi_awburst,
  input  logic                                s00_axi_awvalid,
  output logic                                s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                                s00_axi_wlast,
  input  logic                                s00_axi_wvalid,
  output logic                                s00_axi_wready,
  output logic [C_S00_AXI_ID_WIDTH-1:0]       s00_axi_bid,
  output logic [1:0]                          s00_axi_bresp,
  output logic                                s00_axi_bvalid,
  input  logic                                s00_axi_bready,
  input  logic [C_S00_AXI_ID_WIDTH-1:0]       s00_axi_arid,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [7:0]                          s00_axi_arlen,
  input  logic [1:0]                          s00_axi_arburst,
  input  logic                                s00_axi_arvalid,
  output logic                                s00_axi_arready,
  output logic [C_S00_AXI_ID_WIDTH-1:0]       s00_axi_rid,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                          s00_axi_rresp,
  output logic                                s00_axi_rlast,
  output logic                                s00_axi_rvalid,
  input  logic                                s00_axi_rready
);

  localparam int STRB_W = C_S00_AXI_DATA_WIDTH / 8;
  localparam int SPM_AW = $clog2(SPM_SIZE_IN_BYTE);
  localparam int DEPTH  = SPM_SIZE_IN_BYTE / 16;
  localparam int IDX_W  = (SPM_AW > 4) ? SPM_AW - 4 : 1;
  localparam logic [IDX_W-1:0] IDX_MASK    = (DEPTH > 1) ? '1 : '0;
  localparam logic [1:0]       BURST_FIXED = 2'b00;
  localparam logic [1:0]       RESP_OKAY   = 2'b00;
  localparam logic [1:0]       RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  function automatic logic [IDX_W-1:0] word_index(input logic [C_S00_AXI_ADDR_WIDTH-1:0] addr);
    return IDX_W'(addr >> 4) & IDX_MASK;
  endfunction

  // FIXED holds the word; INCR, WRAP and the reserved encoding all step and wrap at the SPM top.
  function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx, input logic [1:0] burst);
    return (burst == BURST_FIXED) ? idx : ((idx + IDX_W'(1)) & IDX_MASK);
  endfunction

  w_state_t                  w_state_reg, w_state_next;
  logic [C_S00_AXI_ID_WIDTH-1:0] w_id_reg, w_id_next;
  logic [IDX_W-1:0]          w_idx_reg, w_idx_next;
  logic [1:0]                w_burst_reg, w_burst_next;
  logic                      w_err_reg, w_err_next;
  logic                      mem_we;

  r_state_t                  r_state_reg, r_state_next;
  logic [C_S00_AXI_ID_WIDTH-1:0] r_id_reg, r_id_next;
  logic [IDX_W-1:0]          r_idx_reg, r_idx_next;
  logic [1:0]                r_burst_reg, r_burst_next;
  logic                      r_err_reg, r_err_next;
  logic [8:0]                r_beats_reg, r_beats_next;
  logic                      mem_re;
  logic [C_S00_AXI_DATA_WIDTH-1:0] mem_q;

  logic aw_oor;
  logic ar_oor;

`ifdef SPM_RANGE_CHECK_EN
  assign aw_oor = (s00_axi_awaddr >> SPM_AW) != '0;
  assign ar_oor = (s00_axi_araddr >> SPM_AW) != '0;
`else
  assign aw_oor = 1'b0;
  assign ar_oor = 1'b0;
`endif

  // awlen is never needed: wlast alone terminates a write burst.
  logic unused_bits;
  assign unused_bits = ^{s00_axi_awlen, s00_axi_awaddr[3:0], s00_axi_araddr[3:0]};

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      w_state_reg <= W_IDLE;
      w_id_reg    <= '0;
      w_idx_reg   <= '0;
      w_burst_reg <= '0;
      w_err_reg   <= 1'b0;
      r_state_reg <= R_IDLE;
      r_id_reg    <= '0;
      r_idx_reg   <= '0;
      r_burst_reg <= '0;
      r_err_reg   <= 1'b0;
      r_beats_reg <= '0;
    end else begin
      w_state_reg <= w_state_next;
      w_id_reg    <= w_id_next;
      w_idx_reg   <= w_idx_next;
      w_burst_reg <= w_burst_next;
      w_err_reg   <= w_err_next;
      r_state_reg <= r_state_next;
      r_id_reg    <= r_id_next;
      r_idx_reg   <= r_idx_next;
      r_burst_reg <= r_burst_next;
      r_err_reg   <= r_err_next;
      r_beats_reg <= r_beats_next;
    end
  end

  always_comb begin
    w_state_next    = w_state_reg;
    w_id_next       = w_id_reg;
    w_idx_next      = w_idx_reg;
    w_burst_next    = w_burst_reg;
    w_err_next      = w_err_reg;
    mem_we          = 1'b0;
    s00_axi_awready = 1'b0;
    s00_axi_wready  = 1'b0;
    s00_axi_bvalid  = 1'b0;
    s00_axi_bresp   = RESP_OKAY;
    case (w_state_reg)
      W_IDLE: begin
        s00_axi_awready = 1'b1;
        if (s00_axi_awvalid) begin
          w_id_next    = s00_axi_awid;
          w_idx_next   = word_index(s00_axi_awaddr);
          w_burst_next = s00_axi_awburst;
          w_err_next   = aw_oor;
          w_state_next = W_DATA;
        end
      end
      W_DATA: begin
        s00_axi_wready = 1'b1;
        if (s00_axi_wvalid) begin
          mem_we     = !w_err_reg;
          w_idx_next = next_index(w_idx_reg, w_burst_reg);
          if (s00_axi_wlast) begin
            w_state_next = W_RESP;
          end
        end
      end
      W_RESP: begin
        s00_axi_bvalid = 1'b1;
        s00_axi_bresp  = w_err_reg ? RESP_SLVERR : RESP_OKAY;
        if (s00_axi_bready) begin
          w_state_next = W_IDLE;
        end
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  assign s00_axi_bid = w_id_reg;
  assign s00_axi_rid = r_id_reg;

  always_comb begin
    r_state_next    = r_state_reg;
    r_id_next       = r_id_reg;
    r_idx_next      = r_idx_reg;
    r_burst_next    = r_burst_reg;
    r_err_next      = r_err_reg;
    r_beats_next    = r_beats_reg;
    mem_re          = 1'b0;
    s00_axi_arready = 1'b0;
    s00_axi_rvalid  = 1'b0;
    s00_axi_rlast   = 1'b0;
    s00_axi_rresp   = RESP_OKAY;
    s00_axi_rdata   = '0;
    case (r_state_reg)
      R_IDLE: begin
        s00_axi_arready = 1'b1;
        if (s00_axi_arvalid) begin
          r_id_next    = s00_axi_arid;
          r_idx_next   = word_index(s00_axi_araddr);
          r_burst_next = s00_axi_arburst;
          r_err_next   = ar_oor;
          r_beats_next = {1'b0, s00_axi_arlen} + 9'd1;
          r_state_next = R_FETCH;
        end
      end
      R_FETCH: begin
        mem_re       = 1'b1;
        r_state_next = R_DATA;
      end
      R_DATA: begin
        // mem_q only reloads in R_FETCH, so rdata stays put while the master stalls.
        s00_axi_rvalid = 1'b1;
        s00_axi_rlast  = (r_beats_reg == 9'd1);
        s00_axi_rresp  = r_err_reg ? RESP_SLVERR : RESP_OKAY;
        s00_axi_rdata  = r_err_reg ? '0 : mem_q;
        if (s00_axi_rready) begin
          if (r_beats_reg == 9'd1) begin
            r_state_next = R_IDLE;
          end else begin
            r_idx_next   = next_index(r_idx_reg, r_burst_reg);
            r_beats_next = r_beats_reg - 9'd1;
            r_state_next = R_FETCH;
          end
        end
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  // One byte-wide RAM per strobe lane; a same-cycle read sees the pre-write contents.
  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_q;
      always_ff @(posedge s00_axi_aclk) begin
        if (mem_we && s00_axi_wstrb[gi]) begin
          lane_mem[w_idx_reg] <= s00_axi_wdata[gi*8 +: 8];
        end
        if (mem_re) begin
          lane_q <= lane_mem[r_idx_reg];
        end
      end
      assign mem_q[gi*8 +: 8] = lane_q;
    end
  endgenerate

endmodule

// File: tb/tb_axi_spm_responder.sv
// Randomized self-checking bench for axi_spm_responder against a word-array scratchpad model.
module tb_axi_spm_responder;

  localparam int DEPTH = 4096;

  logic         clk;
  logic         areset;
  logic [3:0]   awid;
  logic [39:0]  awaddr;
  logic [7:0]   awlen;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready;
  logic [127:0] wdata;
  logic [15:0]  wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;
  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [3:0]   arid;
  logic [39:0]  araddr;
  logic [7:0]   arlen;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [3:0]   rid;
  logic [127:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;

  int errors = 0;
  int checks = 0;

  logic [127:0] ref_mem [DEPTH];
  logic [127:0] wd [256];
  logic [15:0]  ws [256];

  axi_spm_responder dut (
    .s00_axi_aclk    (clk),
    .s00_axi_areset  (areset),
    .s00_axi_awid    (awid),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awlen   (awlen),
    .s00_axi_awburst (awburst),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wlast   (wlast),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bid     (bid),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_arid    (arid),
    .s00_axi_araddr  (araddr),
    .s00_axi_arlen   (arlen),
    .s00_axi_arburst (arburst),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rid     (rid),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rlast   (rlast),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int word_of(input logic [39:0] a);
    return int'((a / 40'd16) % 40'(DEPTH));
  endfunction

  function automatic bit addr_oor(input logic [39:0] a);
`ifdef SPM_RANGE_CHECK_EN
    return (a / 40'd65536) != 40'd0;
`else
    return (a == 40'h0) && (a != 40'h0);
`endif
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Burst write from wd/ws; the model merges strobed bytes per accepted beat.
  task automatic do_write(input logic [3:0] id, input logic [39:0] addr, input int len,
                          input logic [1:0] burst, input bit gaps);
    int idx;
    bit oor;
    int n;
    idx = word_of(addr);
    oor = addr_oor(addr);
    $display("WR id=%0d addr=%h len=%0d burst=%0d", id, addr, len, burst);
    @(negedge clk);
    awid = id; awaddr = addr; awlen = 8'(len); awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 200) begin @(negedge clk); n++; end
    check("aw_accept", 128'(awready), 128'd1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      if (gaps) begin
        wvalid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wdata = wd[b]; wstrb = ws[b]; wlast = (b == len); wvalid = 1'b1;
      n = 0;
      while (!wready && n < 200) begin @(negedge clk); n++; end
      check("w_accept", 128'(wready), 128'd1);
      @(negedge clk);
      if (!oor) begin
        for (int k = 0; k < 16; k++) begin
          if (ws[b][k]) ref_mem[idx][k*8 +: 8] = wd[b][k*8 +: 8];
        end
      end
      if (burst != 2'b00) idx = (idx + 1) % DEPTH;
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("b_valid", 128'(bvalid), 128'd1);
    check("b_id", 128'(bid), 128'(id));
    check("b_resp", 128'(bresp), oor ? 128'd2 : 128'd0);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("b_done", 128'(bvalid), 128'd0);
    check("aw_return", 128'(awready), 128'd1);
  endtask

  // Burst read; optionally stalls rready for stall_cycles on beat stall_beat.
  task automatic do_read(input logic [3:0] id, input logic [39:0] addr, input int len,
                         input logic [1:0] burst, input int stall_beat, input int stall_cycles);
    int idx;
    bit oor;
    int n;
    logic [127:0] exp;
    idx = word_of(addr);
    oor = addr_oor(addr);
    $display("RD id=%0d addr=%h len=%0d burst=%0d", id, addr, len, burst);
    @(negedge clk);
    arid = id; araddr = addr; arlen = 8'(len); arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 200) begin @(negedge clk); n++; end
    check("ar_accept", 128'(arready), 128'd1);
    @(negedge clk);
    arvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      n = 1;
      while (!rvalid && n < 200) begin @(negedge clk); n++; end
      check("r_valid", 128'(rvalid), 128'd1);
      check("r_spacing", 128'(n), 128'd2);
      exp = oor ? 128'd0 : ref_mem[idx];
      check("r_id", 128'(rid), 128'(id));
      check($sformatf("r_data[%0d]", b), rdata, exp);
      check("r_resp", 128'(rresp), oor ? 128'd2 : 128'd0);
      check("r_last", 128'(rlast), 128'(b == len));
      if (b == stall_beat) begin
        repeat (stall_cycles) begin
          @(negedge clk);
          check("r_hold_valid", 128'(rvalid), 128'd1);
          check("r_hold_data", rdata, exp);
        end
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
      if (burst != 2'b00) idx = (idx + 1) % DEPTH;
    end
    check("r_done", 128'(rvalid), 128'd0);
    check("ar_return", 128'(arready), 128'd1);
  endtask

  initial begin
    int n;
    int len;
    int st;
    logic [39:0] a;
    logic [1:0] bu;

    areset = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    #2 areset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_awready", 128'(awready), 128'd1);
    check("rst_arready", 128'(arready), 128'd1);
    check("rst_wready", 128'(wready), 128'd0);
    check("rst_bvalid", 128'(bvalid), 128'd0);
    check("rst_rvalid", 128'(rvalid), 128'd0);
    check("rst_rlast", 128'(rlast), 128'd0);
    check("rst_bid", 128'(bid), 128'd0);
    check("rst_rid", 128'(rid), 128'd0);
    check("rst_rdata", rdata, 128'd0);
    check("rst_resp", 128'({bresp, rresp}), 128'd0);
    areset = 1'b0;

    // Fill words 0..255 with one 256-beat burst, then read it back in one 256-beat burst.
    for (int b = 0; b < 256; b++) begin wd[b] = rand128(); ws[b] = 16'hFFFF; end
    do_write(4'd1, 40'h0, 255, 2'b01, 1'b0);
    do_read(4'd2, 40'h0, 255, 2'b01, -1, 0);

    for (int b = 0; b < 4; b++) begin wd[b] = 128'hA0 + 128'(b); ws[b] = 16'hFFFF; end
    do_write(4'd3, 40'h100, 3, 2'b01, 1'b0);
    do_read(4'd5, 40'h100, 3, 2'b01, -1, 0);

    wd[0] = '1; ws[0] = 16'hFFFF;
    do_write(4'd4, 40'h200, 0, 2'b01, 1'b0);
    wd[0] = 128'h11; ws[0] = 16'h0001;
    do_write(4'd4, 40'h200, 0, 2'b01, 1'b0);
    check("strb_model", ref_mem[32], {{120{1'b1}}, 8'h11});
    do_read(4'd6, 40'h200, 0, 2'b01, -1, 0);

    do_read(4'd2, 40'h100, 2, 2'b00, -1, 0);

    for (int b = 0; b < 2; b++) begin wd[b] = rand128(); ws[b] = 16'hFFFF; end
    do_write(4'd8, 40'hFFF0, 1, 2'b01, 1'b0);
    do_read(4'd8, 40'hFFF0, 1, 2'b01, -1, 0);
    do_read(4'd9, 40'h0, 0, 2'b01, -1, 0);

    // Write issued while a read burst is stalled on rready.
    for (int b = 0; b < 2; b++) begin wd[b] = rand128(); ws[b] = 16'hFFFF; end
    fork
      do_read(4'd5, 40'h100, 3, 2'b01, 1, 5);
      begin
        repeat (3) @(negedge clk);
        do_write(4'd7, 40'h300, 1, 2'b01, 1'b0);
      end
    join
    do_read(4'd7, 40'h300, 1, 2'b01, -1, 0);

    do_read(4'd10, 40'h10000, 1, 2'b01, -1, 0);

    for (int t = 0; t < 40; t++) begin
      len = $urandom_range(0, 7);
      bu = 2'($urandom_range(0, 3));
      st = $urandom_range(0, 255 - 8);
      a = (40'(st) << 4) | 40'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) a = a | (40'h10000 << $urandom_range(0, 23));
      if ($urandom_range(0, 1) == 0) begin
        for (int b = 0; b <= len; b++) begin
          wd[b] = rand128();
          ws[b] = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'($urandom);
        end
        do_write(4'($urandom_range(0, 15)), a, len, bu, 1'b1);
      end else begin
        do_read(4'($urandom_range(0, 15)), a, len, bu,
                int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
      end
    end

    // Asynchronous reset in the middle of a read burst.
    $display("RD id=9 addr=0000000100 len=3 burst=1 (reset mid-burst)");
    @(negedge clk);
    arid = 4'd9; araddr = 40'h100; arlen = 8'd3; arburst = 2'b01; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 200) begin @(negedge clk); n++; end
    check("rst_mid_pre", 128'(rvalid), 128'd1);
    #2 areset = 1'b1;
    #1;
    check("rst_mid_rvalid", 128'(rvalid), 128'd0);
    check("rst_mid_rlast", 128'(rlast), 128'd0);
    check("rst_mid_rid", 128'(rid), 128'd0);
    check("rst_mid_arready", 128'(arready), 128'd1);
    @(negedge clk);
    areset = 1'b0;
    do_read(4'd1, 40'h100, 3, 2'b01, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_spm_responder.md
Name: axi_spm_responder

Overview:
- AXI4 slave that terminates the compact-ID master port of the translator and serves it from an on-chip scratchpad memory (SPM).
- Accepts the renamed IDs (0..READ_DEPTH-1 / 0..WRITE_DEPTH-1) and bleached addresses, and returns R/B responses carrying the same ID.
- The read and write channels are independent FSMs. Each channel holds one outstanding transaction.
- Used as the SPM endpoint and as the bench responder for the translator.

Parameters:
- SPM_SIZE_IN_BYTE, 65536, SPM capacity; power of two, at least 16.
- C_S00_AXI_ID_WIDTH, 4, ID width; must cover log2 of READ_DEPTH and WRITE_DEPTH.
- C_S00_AXI_ADDR_WIDTH, 40, address width.
- C_S00_AXI_DATA_WIDTH, 128, data width; fixed at 128. A beat is 16 bytes.

Ports:
- s00_axi_aclk  in  1  clock.
- s00_axi_areset  in  1  asynchronous active-high reset.
- s00_axi_awid/awaddr/awlen/awburst  in  ID/ADDR/8/2  write address.
- s00_axi_awvalid  in  1;  s00_axi_awready  out  1.
- s00_axi_wdata/wstrb/wlast/wvalid  in  128/16/1/1;  s00_axi_wready  out  1.
- s00_axi_bid/bresp/bvalid  out  ID/2/1;  s00_axi_bready  in  1.
- s00_axi_arid/araddr/arlen/arburst  in  ID/ADDR/8/2  read address.
- s00_axi_arvalid  in  1;  s00_axi_arready  out  1.
- s00_axi_rid/rdata/rresp/rlast/rvalid  out  ID/128/2/1/1;  s00_axi_rready  in  1.

Behaviour:
- Reset (asynchronous, active-high, any cycle):
  - Both FSMs go to IDLE. Any in-flight burst is abandoned; SPM contents are not cleared.
  - awready=1, arready=1. wready, bvalid, rvalid, rlast = 0. bid, rid, rdata = 0. bresp, rresp = 2'b00.
- Word index = addr[log2(SPM_SIZE_IN_BYTE)-1:4]. Address bits below 4 and above the SPM range are ignored; default builds wrap modulo SPM size.
- Burst stride:
  - INCR (01) and WRAP (10): next index = index+1, modulo SPM depth.
  - FIXED (00): index held.
  - Reserved (11): treated as INCR.
  - awsize/arsize are not ported; every beat is 16 bytes.
- Write FSM:
  - W_IDLE: awready=1. On awvalid&awready, latch id/index/burst -> W_DATA.
  - W_DATA: wready=1. Each wvalid beat writes its bytes where wstrb[i]=1, then advances the index. The beat with wlast -> W_RESP. awlen is not checked; wlast alone ends the burst.
  - W_RESP: bvalid=1, bid=latched id, bresp=OKAY. On bready -> W_IDLE; awready returns the next cycle.
  - wvalid while in W_IDLE is ignored (wready=0).
- Read FSM:
  - R_IDLE: arready=1. On handshake, latch id/index/burst and beats=arlen+1 -> R_FETCH.
  - R_FETCH: registered SPM read -> R_DATA.
  - R_DATA: rvalid=1, rid=latched id, rresp=OKAY, rlast=1 on the final beat. rdata is held stable while rready=0.
  - On rvalid&rready: last beat -> R_IDLE; otherwise advance the index -> R_FETCH.
  - Latency: first rvalid 2 cycles after the AR handshake. Throughput: one beat per 2 cycles.
  - arlen=255 gives a 256-beat burst; the beat counter is 9 bits.
- Simultaneous events:
  - A write beat and a read fetch to the same word in the same cycle: the read returns the old data (read-before-write).
  - Read and write FSMs never stall each other.

Optional Feature:
- Macro: SPM_RANGE_CHECK_EN.
- Defined:
  - An AW/AR whose address bits at or above log2(SPM_SIZE_IN_BYTE) (up to ADDR_WIDTH-1) are non-zero is flagged at the handshake.
  - A flagged write: beats are consumed with no SPM update, then bresp=SLVERR (2'b10).
  - A flagged read: every beat returns rdata=0 and rresp=SLVERR. The beat count and rlast are unchanged.
  - An INCR burst that crosses the top of the SPM still wraps and stays OKAY; only the start address is checked.
- Undefined: no check; all addresses wrap modulo SPM size and all responses are OKAY.

Test Plan:
- Reset -> awready=1, arready=1, bvalid=0, rvalid=0; assert reset mid-read-burst -> rvalid drops the same cycle.
- AW id=3 addr=0x100 len=3 INCR, 4 beats data 0xA0..0xA3 with wstrb=all ones, bready=1 -> bid=3 bresp=0 one cycle after wlast. Then AR id=5 addr=0x100 len=3 -> rid=5, rdata 0xA0..0xA3, rlast on beat 4 only, first rvalid 2 cycles after AR.
- Write 0xFF..FF to 0x200, then write 0x11 with wstrb=0x0001 -> read of 0x200 returns 0xFF..FF11.
- FIXED read len=2 at 0x100 -> the same word 3 times. INCR write at SPM_SIZE-16 with len=1 -> the second beat lands at word 0.
- Hold rready=0 for 5 cycles mid-burst -> rvalid and rdata stable. Issue AW during the read -> the write completes independently.
- With SPM_RANGE_CHECK_EN defined and SPM 64 KiB: AR at 0x10000 len=1 -> 2 beats rresp=2'b10 rdata=0. Without the macro, the same AR returns word 0 data with OKAY.
